rv32im_div: RTL and testbench
=============================

Name: rv32im_div

Overview:
- Iterative restoring divider for the M-extension execute stage; the division counterpart to the shift-add multiplier.
- Accepts a one-cycle start pulse with dividend, divisor and operation select, then runs one quotient bit per clock.
- Delivers a single XLEN-bit result (quotient or remainder) with a one-cycle valid pulse.
- Resolves RISC-V divide-by-zero and signed-overflow cases without iterating.

Parameters:
XLEN, 32, operand/result width; must be a power of two (counter relies on MSB rollover)

Ports:
clk_i  input  1  clock, all state on rising edge
reset_ni  input  1  asynchronous, active-low reset
start_i  input  1  one-cycle start pulse; samples operands and op_i
op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
operand1_i  input  XLEN  dividend
operand2_i  input  XLEN  divisor
busy_o  output  1  iteration in progress
valid_o  output  1  one-cycle pulse, result_o valid
result_o  output  XLEN  quotient or remainder; held until next completion

Behaviour:
- Reset (async assert, reset_ni=0):
  - busy_o=0, valid_o=0, result_o=0, FSM=IDLE, counter=0.
  - Takes effect immediately, including mid-operation. The operation is abandoned and no valid_o is produced.
- FSM states: IDLE, CALC, FIX.
- Start, edge 0 (start_i=1 sampled in any state):
  - Latches op_i, signed flags, and magnitudes of both operands. Magnitudes are two's-complement absolute values for DIV/REM, raw values for DIVU/REMU.
  - Clears the partial remainder and counter.
  - If not a special case: FSM=CALC, busy_o=1, valid_o=0.
- Special cases, decided at edge 0 and completed at edge 1:
  - FSM goes to FIX directly; busy_o never asserts; valid_o=1 after edge 1.
  - Divisor==0: DIV and DIVU give all-ones; REM and REMU give operand1_i.
  - DIV/REM with operand1_i==1<<(XLEN-1) and operand2_i==all-ones: DIV gives operand1_i, REM gives 0.
- CALC, one restoring step per edge for XLEN edges:
  - trial = {rem[XLEN-2:0], dividend MSB} - divisor, computed at XLEN+1 bits.
  - If trial is non-negative: rem=trial[XLEN-1:0] and quotient bit=1. Otherwise rem keeps the shifted value and quotient bit=0.
  - Dividend/quotient register shifts left by 1.
  - Counter is $clog2(XLEN)+1 bits. When counter+1 sets its MSB, FSM goes to FIX.
- FIX, one edge:
  - Quotient is negated if DIV and the input signs differed.
  - Remainder is negated if REM and the dividend was negative.
  - result_o is loaded from these; busy_o=0; valid_o=1; FSM=IDLE.
- Latency:
  - Normal operation: valid_o high in the cycle after edge XLEN+1 (33 cycles at XLEN=32). busy_o is high for exactly XLEN+1 cycles.
- valid_o is high for exactly one cycle, then returns to 0.
- result_o only changes on a completion edge or on reset.
- start_i while busy_o=1 aborts the current operation and restarts with the new operands. No valid_o is produced for the aborted operation.
- start_i in the same cycle valid_o is high is accepted normally; valid_o drops next cycle.
- Operand inputs are don't-care except on the start edge.
- All arithmetic is unsigned on magnitudes. No sign handling occurs inside CALC.

Test Plan:
- DIVU 100/7, then REMU 100/7 -> result_o=14, then 2. valid_o pulses exactly 33 cycles after each start; busy_o is high for 33 cycles.
- DIV 0xFFFFFF9C(-100)/7 -> 0xFFFFFFF2(-14). REM of the same operands -> 0xFFFFFFFE(-2). REM 100/0xFFFFFFF9(-7) -> 2.
- Divide by zero with operand1_i=0x12345678 -> DIV/DIVU give 0xFFFFFFFF, REM/REMU give 0x12345678. valid_o one cycle after start; busy_o never high.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0. Both 1-cycle latency. DIVU of the same operands iterates and gives 0.
- Abort and reset: start DIVU 1000/3, restart at cycle 10 with DIVU 50/5 -> single valid_o 33 cycles after the second start, result 10. Separately, pull reset_ni low at cycle 15 of an operation -> busy_o and valid_o drop immediately, result_o=0, no later valid_o.
- Back-to-back: new start in the valid_o cycle -> new operation runs with correct latency; previous result_o holds until the new completion.

Source files
------------

// File: rtl/rv32im_div_if.sv
// Start/result handshake between the execute stage and the iterative divider.
interface rv32im_div_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] operand1_i;
  logic [XLEN-1:0] operand2_i;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, op_i, operand1_i, operand2_i,
    input  busy_o, valid_o, result_o
  );

  modport slave (
    input  start_i, op_i, operand1_i, operand2_i,
    output busy_o, valid_o, result_o
  );
endinterface

// File: rtl/rv32im_div.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU: one quotient bit
// per clock on operand magnitudes, sign fix-up in a final FIX cycle.
module rv32im_div #(
  parameter int XLEN = 32
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  rv32im_div_if.slave   bus
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  function automatic logic [XLEN-1:0] mag(input logic signed [XLEN-1:0] v,
                                          input logic is_signed);
    logic [XLEN-1:0] r;
    r = v;
    if (is_signed && v[XLEN-1]) r = -v;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v,
                                             input logic cond);
    return cond ? (~v + 1'b1) : v;
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic            special_q, special_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] dq_q, dq_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] div_q, div_d;

  logic signed [XLEN-1:0] op1_s, op2_s;
  logic            in_signed, div_zero, overflow;
  logic [XLEN-1:0] shifted;
  logic [XLEN:0]   trial;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    special_d = special_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    result_d  = result_q;
    dq_d      = dq_q;
    rem_d     = rem_q;
    div_d     = div_q;

    op1_s     = bus.operand1_i;
    op2_s     = bus.operand2_i;
    in_signed = ~bus.op_i[0];
    div_zero  = (bus.operand2_i == '0);
    overflow  = in_signed && (bus.operand1_i == MIN_NEG) && (bus.operand2_i == '1);

    // Trial subtraction at XLEN+1 bits; bit XLEN is the borrow
    shifted = {rem_q[XLEN-2:0], dq_q[XLEN-1]};
    trial   = {1'b0, shifted} - {1'b0, div_q};

    if (bus.start_i) begin
      op_d    = bus.op_i;
      q_neg_d = in_signed && (op1_s[XLEN-1] ^ op2_s[XLEN-1]);
      r_neg_d = in_signed && op1_s[XLEN-1];
      dq_d    = mag(op1_s, in_signed);
      div_d   = mag(op2_s, in_signed);
      rem_d   = '0;
      cnt_d   = '0;
      if (div_zero) begin
        special_d = 1'b1;
        dq_d      = bus.op_i[1] ? bus.operand1_i : '1;
        busy_d    = 1'b0;
        state_d   = FIX;
      end else if (overflow) begin
        special_d = 1'b1;
        dq_d      = bus.op_i[1] ? '0 : bus.operand1_i;
        busy_d    = 1'b0;
        state_d   = FIX;
      end else begin
        special_d = 1'b0;
        busy_d    = 1'b1;
        state_d   = CALC;
      end
    end else begin
      case (state_q)
        CALC: begin
          rem_d = trial[XLEN] ? shifted : trial[XLEN-1:0];
          dq_d  = {dq_q[XLEN-2:0], ~trial[XLEN]};
          cnt_d = cnt_q + CW'(1);
          if (cnt_d[CW-1]) state_d = FIX;
        end
        FIX: begin
          if (special_q)     result_d = dq_q;
          else if (op_q[1])  result_d = neg_if(rem_q, r_neg_q);
          else               result_d = neg_if(dq_q, q_neg_q);
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      special_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      special_q <= special_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
    end
  end

  // Datapath registers carry no reset: they are always reloaded on start
  always_ff @(posedge clk_i) begin
    dq_q  <= dq_d;
    rem_q <= rem_d;
    div_q <= div_d;
  end

  assign bus.busy_o   = busy_q;
  assign bus.valid_o  = valid_q;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_rv32im_div.sv
// Directed bench for rv32im_div: arithmetic reference model plus latency
// countdown, compared every cycle, with literal expectations per vector.
module tb_rv32im_div;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  rv32im_div_if #(.XLEN(32)) bus ();

  rv32im_div #(.XLEN(32)) dut (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'h0 : a;
    case (op)
      2'b00:   return 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (b == 32'h0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending operation counts down to its completion edge
  logic        m_pend = 1'b0;
  int          m_left = 0;
  logic [31:0] m_res  = '0;
  logic        m_valid = 1'b0;
  logic        m_busy  = 1'b0;
  logic [31:0] m_held  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend  <= 1'b0;
      m_left  <= 0;
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
      m_held  <= '0;
    end else if (bus.start_i) begin
      m_pend  <= 1'b1;
      m_left  <= ref_lat(bus.op_i, bus.operand1_i, bus.operand2_i);
      m_res   <= ref_result(bus.op_i, bus.operand1_i, bus.operand2_i);
      m_busy  <= (ref_lat(bus.op_i, bus.operand1_i, bus.operand2_i) != 1);
      m_valid <= 1'b0;
    end else if (m_pend && m_left == 1) begin
      m_pend  <= 1'b0;
      m_left  <= 0;
      m_valid <= 1'b1;
      m_held  <= m_res;
      m_busy  <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      if (m_pend) m_left <= m_left - 1;
    end
  end

  always @(negedge clk) begin
    check("valid_o", {31'b0, bus.valid_o}, {31'b0, m_valid});
    check("busy_o", {31'b0, bus.busy_o}, {31'b0, m_busy});
    check("result_o", bus.result_o, m_held);
  end

  task automatic start_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    bus.start_i    = 1'b1;
    bus.op_i       = op;
    bus.operand1_i = a;
    bus.operand2_i = b;
    @(posedge clk);
    #1;
    bus.start_i    = 1'b0;
    bus.op_i       = 2'b11;
    bus.operand1_i = 32'hDEAD_BEEF;
    bus.operand2_i = 32'h0000_0000;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.valid_o) return;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat);
    int n;
    check({name, " model"}, ref_result(op, a, b), exp_res);
    start_op(op, a, b);
    wait_valid(n);
    if (n >= 40 && !bus.valid_o) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: no valid_o within 40 cycles", name);
    end else begin
      check({name, " latency"}, 32'(n), 32'(exp_lat));
      check({name, " result"}, bus.result_o, exp_res);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int seen;
    bus.start_i    = 1'b0;
    bus.op_i       = 2'b00;
    bus.operand1_i = '0;
    bus.operand2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy_o", {31'b0, bus.busy_o}, 32'h0);
    check("reset valid_o", {31'b0, bus.valid_o}, 32'h0);
    check("reset result_o", bus.result_o, 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Back-to-back pairs: each start lands in the previous valid_o cycle
    run_op("DIVU 100/7", 2'b01, 32'd100, 32'd7, 32'd14, 33);
    run_op("REMU 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 33);
    idle(3);
    run_op("DIV -100/7", 2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);
    run_op("REM -100/7", 2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33);
    run_op("REM 100/-7", 2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2, 33);
    run_op("DIV -7/-2", 2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 33);
    run_op("DIV 7/-2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("REM 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run_op("DIVU max/1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
    run_op("REMU max/8..1", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33);
    idle(2);

    run_op("DIV by 0", 2'b00, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 1);
    run_op("DIVU by 0", 2'b01, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 1);
    run_op("REM by 0", 2'b10, 32'h1234_5678, 32'h0, 32'h1234_5678, 1);
    run_op("REMU by 0", 2'b11, 32'h1234_5678, 32'h0, 32'h1234_5678, 1);
    idle(2);
    run_op("DIV ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("REM ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
    run_op("DIVU no ovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33);
    idle(3);

    // Restart mid-operation: only the second operation completes
    start_op(2'b01, 32'd1000, 32'd3);
    idle(9);
    run_op("DIVU abort 50/5", 2'b01, 32'd50, 32'd5, 32'd10, 33);
    idle(3);

    // Asynchronous reset part way through an operation
    start_op(2'b01, 32'd100, 32'd7);
    idle(14);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst busy_o", {31'b0, bus.busy_o}, 32'h0);
    check("async rst valid_o", {31'b0, bus.valid_o}, 32'h0);
    check("async rst result_o", bus.result_o, 32'h0);
    idle(2);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.valid_o) seen++;
    end
    check("no valid after reset", 32'(seen), 32'd0);

    run_op("DIVU after reset", 2'b01, 32'd81, 32'd9, 32'd9, 33);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
